frame_overlay: RTL



---
 rtl/frame_overlay.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/frame_overlay.sv
// Draws up to NUM_WIN rectangular window borders on a scaled pixel grid; configuration is
// shadowed and committed at the start of vertical blank. Blink support: FRAME_OVERLAY_BLINK_EN.
module frame_overlay #(
   parameter int NUM_WIN      = 4,
   parameter int SCALE_SHIFT  = 2,
   parameter int COORD_W      = 8,
   parameter int THICK_W      = 3,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [9:0]                                    counter_x,
   input  logic [9:0]                                    counter_y,
   input  logic                                          cfg_valid,
   output logic                                          cfg_ready,
   input  logic [$clog2((NUM_WIN > 1) ? NUM_WIN : 2)-1:0] cfg_win,
   input  logic [COORD_W-1:0]                            cfg_x0,
   input  logic [COORD_W-1:0]                            cfg_x1,
   input  logic [COORD_W-1:0]                            cfg_y0,
   input  logic [COORD_W-1:0]                            cfg_y1,
   input  logic [THICK_W-1:0]                            cfg_thick,
   input  logic                                          cfg_en,
   input  logic                                          cfg_blink,
   output logic                                          draw_frame,
   output logic [$clog2((NUM_WIN > 1) ? NUM_WIN : 2)-1:0] draw_win_id,
   output logic                                          frame_tick
);

   localparam int IDW = $clog2((NUM_WIN > 1) ? NUM_WIN : 2);
   localparam int SW  = COORD_W + 2;

   typedef struct packed {
      logic [COORD_W-1:0] x0, x1, y0, y1;
      logic [THICK_W-1:0] thick;
      logic               en;
`ifdef FRAME_OVERLAY_BLINK_EN
      logic               blink;
`endif
   } win_t;

   // Handshake: a word transfers on any rising clk edge where cfg_valid && cfg_ready;
   // cfg_ready drops only in reset, the cycle after it, and the commit cycle.
   logic at_commit_pos, commit, accept;
   logic ready_q, ready_d;
   win_t cfg_word;
   win_t shadow_q [NUM_WIN];
   win_t shadow_d [NUM_WIN];
   win_t active_q [NUM_WIN];
   win_t active_d [NUM_WIN];

   assign at_commit_pos = (counter_x == 10'd0) && (counter_y == 10'(V_ACTIVE));
   assign commit        = ~rst & at_commit_pos;
   assign cfg_ready     = ready_q & ~at_commit_pos;
   assign frame_tick    = commit;
   assign accept        = cfg_valid & cfg_ready;
   assign ready_d       = 1'b1;

   always_comb begin
      cfg_word       = '0;
      cfg_word.x0    = cfg_x0;
      cfg_word.x1    = cfg_x1;
      cfg_word.y0    = cfg_y0;
      cfg_word.y1    = cfg_y1;
      cfg_word.thick = cfg_thick;
      cfg_word.en    = cfg_en;
`ifdef FRAME_OVERLAY_BLINK_EN
      cfg_word.blink = cfg_blink;
`endif
   end

   // Out-of-range window indices match no slot, so such words are accepted and dropped.
   always_comb begin
      shadow_d = shadow_q;
      if (accept) begin
         for (int i = 0; i < NUM_WIN; i++) begin
            if (cfg_win == IDW'(i)) shadow_d[i] = cfg_word;
         end
      end
      active_d = commit ? shadow_q : active_q;
   end

`ifdef FRAME_OVERLAY_BLINK_EN
   localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
   logic           blink_phase_q, blink_phase_d;

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (commit) begin
         if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BCW'(1);
         end
      end
   end
`else
   logic unused_blink;
   assign unused_blink = cfg_blink | (BLINK_FRAMES == 0);
`endif

   // Stage 1: grid coordinates and active-area flag.
   logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
   logic               act_q, act_d;

   assign sx_d  = COORD_W'(counter_x >> SCALE_SHIFT);
   assign sy_d  = COORD_W'(counter_y >> SCALE_SHIFT);
   assign act_d = (counter_x < 10'(H_ACTIVE)) && (counter_y < 10'(V_ACTIVE));

   // Stage 2: per-window border test against the committed configuration.
   logic [NUM_WIN-1:0] win_draw;

   for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
      logic signed [SW-1:0] sx_s, sy_s, x0_s, x1_s, y0_s, y1_s, t_s;
      logic                 outer, border, shown;

      assign sx_s = $signed(SW'(sx_q));
      assign sy_s = $signed(SW'(sy_q));
      assign x0_s = $signed(SW'(active_q[i].x0));
      assign x1_s = $signed(SW'(active_q[i].x1));
      assign y0_s = $signed(SW'(active_q[i].y0));
      assign y1_s = $signed(SW'(active_q[i].y1));
      assign t_s  = (active_q[i].thick == '0) ? SW'(1) : $signed(SW'(active_q[i].thick));

      assign outer  = (x0_s <= sx_s) && (sx_s <= x1_s) && (y0_s <= sy_s) && (sy_s <= y1_s);
      // An over-thick border leaves no interior, which yields a filled rectangle.
      assign border = outer && ((sx_s < x0_s + t_s) || (sx_s > x1_s - t_s) ||
                                (sy_s < y0_s + t_s) || (sy_s > y1_s - t_s));
`ifdef FRAME_OVERLAY_BLINK_EN
      assign shown  = active_q[i].en && (!active_q[i].blink || blink_phase_q);
`else
      assign shown  = active_q[i].en;
`endif
      assign win_draw[i] = shown & border;
   end

   logic           draw_frame_q, draw_frame_d;
   logic [IDW-1:0] draw_win_id_q, draw_win_id_d;

   always_comb begin
      draw_frame_d  = act_q & (|win_draw);
      draw_win_id_d = '0;
      if (act_q) begin
         for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_draw[i]) draw_win_id_d = IDW'(i);
         end
      end
   end

   assign draw_frame  = draw_frame_q;
   assign draw_win_id = draw_win_id_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q       <= 1'b0;
         shadow_q      <= '{default: '0};
         active_q      <= '{default: '0};
         sx_q          <= '0;
         sy_q          <= '0;
         act_q         <= 1'b0;
         draw_frame_q  <= 1'b0;
         draw_win_id_q <= '0;
`ifdef FRAME_OVERLAY_BLINK_EN
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
`endif
      end else begin
         ready_q       <= ready_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         act_q         <= act_d;
         draw_frame_q  <= draw_frame_d;
         draw_win_id_q <= draw_win_id_d;
`ifdef FRAME_OVERLAY_BLINK_EN
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
`endif
      end
   end

endmodule
